// File: rtl/fetch_ifid_stage.sv
// Instruction fetch stage with PC, single-outstanding imem port and IF/ID register.
// Responses that arrive while IF/ID is stalled are parked in a one-entry hold buffer.
module fetch_ifid_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pc_write,
  input  logic            i_if_id_write,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_if_id_pc,
  output logic [XLEN-1:0] o_if_id_instr,
  output logic            o_if_id_valid,
  output logic [4:0]      o_if_id_rs1,
  output logic [4:0]      o_if_id_rs2
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetch_pc;
  logic            kill;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_instr;
  logic            accept;
  logic [XLEN-1:0] redir_tgt;

  assign o_imem_req = (state == S_IDLE) & i_pc_write
                    & ~i_redirect & ~i_rst;
  assign o_imem_addr = pc;
  assign accept = o_imem_req & i_imem_ready;
  assign redir_tgt = i_redirect_pc & ~XLEN'(3);

  assign o_if_id_rs1 = o_if_id_instr[19:15];
  assign o_if_id_rs2 = o_if_id_instr[24:20];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      fetch_pc      <= '0;
      kill          <= 1'b0;
      hold_pc       <= '0;
      hold_instr    <= '0;
      o_if_id_pc    <= '0;
      o_if_id_instr <= NOP_INSTR;
      o_if_id_valid <= 1'b0;
    end else if (i_redirect) begin
      pc            <= redir_tgt;
      o_if_id_pc    <= '0;
      o_if_id_instr <= NOP_INSTR;
      o_if_id_valid <= 1'b0;
      unique case (state)
        S_WAIT: begin
          // A response in the redirect cycle belongs to the wrong path.
          if (i_imem_rvalid) begin
            state <= S_IDLE;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        S_HOLD:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else begin
      // Bubble by default; a delivery below overrides it.
      if (i_if_id_write) begin
        o_if_id_pc    <= '0;
        o_if_id_instr <= NOP_INSTR;
        o_if_id_valid <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            fetch_pc <= pc;
            pc       <= pc + XLEN'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= S_IDLE;
            end else if (i_if_id_write) begin
              o_if_id_pc    <= fetch_pc;
              o_if_id_instr <= i_imem_rdata;
              o_if_id_valid <= 1'b1;
              state         <= S_IDLE;
            end else begin
              hold_pc    <= fetch_pc;
              hold_instr <= i_imem_rdata;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_if_id_write) begin
            o_if_id_pc    <= hold_pc;
            o_if_id_instr <= hold_instr;
            o_if_id_valid <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
